// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the two master request/grant handshakes, the shared dmem bus and the read-data
//   return for dmem_port_arbiter.
//   Port 0 (CPU):  req0, we0, addr0, wdata0 -> gnt0, ack0
//   Port 1 (I/O):  req1, we1, addr1, wdata1 -> gnt1, ack1
//   dmem side:     mem_we, mem_addr, mem_wdata -> dmem;  mem_rdata <- dmem
//   Shared:        rdata (read-data return), owner (00 idle, 01 port 0, 10 port 1)
//   Modports: slave = arbiter view, master = masters + memory (environment) view.
interface dmem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          ack0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          ack1;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rdata;
    logic [1:0]    owner;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, ack0, gnt1, ack1,
        output mem_we, mem_addr, mem_wdata, rdata, owner
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, ack0, gnt1, ack1,
        input  mem_we, mem_addr, mem_wdata, rdata, owner
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Round-robin arbiter sharing the single data-memory port between the CPU load/store path
//   (port 0) and the I/O scan/refresh engine (port 1). Grant is registered, an owner keeps the
//   port for as long as it holds req high, and release hands straight over to a pending
//   requester with no idle cycle. dmem returns read data one cycle after the address, which
//   lines up with the registered ack.
//   Ports:
//     clock   - system clock, rising edge
//     resetn  - synchronous active-low reset
//     bus_io  - dmem_port_arbiter_if.slave: both master handshakes, dmem bus, rdata, owner
//   Parameters: AW/DW address/data width, MAX_HOLD hold limit (2..255, timeout build only).
//   Optional feature: define DMEM_ARB_TIMEOUT_EN to force hand-over once an owner has held the
//   port for MAX_HOLD cycles while the other port is requesting.
module dmem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic                  clock,
    input logic                  resetn,
    dmem_port_arbiter_if.slave   bus_io
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    localparam logic [7:0] HoldLimit = 8'(MAX_HOLD);

    state_e state_q, state_d;
    logic   last_q, last_d;     // port that owned the bus most recently (loses the next tie)
    logic   ack0_q, ack1_q;
    logic   gnt0, gnt1;
    logic   hold_expired;

    assign gnt0 = (state_q == StOwn0);
    assign gnt1 = (state_q == StOwn1);

`ifdef DMEM_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    // hold_q counts owned cycles already completed, so the limit is reached in the
    // MAX_HOLD-th owned cycle and hand-over happens at the edge ending it. Once saturated,
    // a late request from the other port is honoured at the first edge that samples it.
    assign hold_expired = (hold_q >= HoldLimit - 8'd1);

    always_comb begin
        hold_d = hold_q;
        if (state_d != state_q) begin
            hold_d = 8'd0;
        end else if (state_q != StIdle && hold_q < HoldLimit) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    // Without the timeout an owner is never preempted; MAX_HOLD has no effect.
    logic unused_hold_limit;
    assign unused_hold_limit = ^HoldLimit;
    assign hold_expired      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.req0 && bus_io.req1) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (bus_io.req0) begin
                    state_d = StOwn0;
                end else if (bus_io.req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!bus_io.req0) begin
                    state_d = bus_io.req1 ? StOwn1 : StIdle;
                    last_d  = 1'b0;
                end else if (hold_expired && bus_io.req1) begin
                    state_d = StOwn1;
                    last_d  = 1'b0;
                end
            end
            StOwn1: begin
                if (!bus_io.req1) begin
                    state_d = bus_io.req0 ? StOwn0 : StIdle;
                    last_d  = 1'b1;
                end else if (hold_expired && bus_io.req0) begin
                    state_d = StOwn0;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset drops any access in flight without acking it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ack0_q  <= gnt0 & bus_io.req0;
            ack1_q  <= gnt1 & bus_io.req1;
        end
    end

    always_comb begin
        bus_io.mem_addr  = '0;
        bus_io.mem_wdata = '0;
        if (gnt0) begin
            bus_io.mem_addr  = bus_io.addr0;
            bus_io.mem_wdata = bus_io.wdata0;
        end else if (gnt1) begin
            bus_io.mem_addr  = bus_io.addr1;
            bus_io.mem_wdata = bus_io.wdata1;
        end
    end

    assign bus_io.mem_we = (gnt0 & bus_io.we0 & bus_io.req0) | (gnt1 & bus_io.we1 & bus_io.req1);
    assign bus_io.gnt0   = gnt0;
    assign bus_io.gnt1   = gnt1;
    assign bus_io.ack0   = ack0_q;
    assign bus_io.ack1   = ack1_q;
    assign bus_io.rdata  = bus_io.mem_rdata;
    assign bus_io.owner  = {gnt1, gnt0};

endmodule
